// File: rtl/iir_biquad_cascade.sv
// Cascade of N_SECT direct-form-II biquads sharing a single multiplier,
// one multiply-accumulate step per clock. State sequence per section:
//   IDLE | wait for sample / accept coef writes and state clears
//   A1   | acc = x<<FRAC_W + a1*w1      A2 | acc += a2*w2
//   W    | w = round/sat(acc)           B0 | acc = b0*w
//   B1   | acc += b1*w1                 B2 | acc += b2*w2
//   Y    | y = round/sat(acc), shift delay line
//   OUT  | hold result until out_ready
module iir_biquad_cascade #(
  parameter int DATA_W = 32,
  parameter int COEF_W = 32,
  parameter int FRAC_W = 22,
  parameter int N_SECT = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic signed [DATA_W-1:0]       data_in,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic signed [DATA_W-1:0]       offset,
  input  logic                           bypass,
  input  logic                           coef_we,
  input  logic [$clog2(5*N_SECT)-1:0]    coef_addr,
  input  logic signed [COEF_W-1:0]       coef_data,
  input  logic                           clr_state,
  output logic signed [DATA_W-1:0]       yn,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           ovf
);

  localparam int ADDR_W = $clog2(5*N_SECT);
  localparam int SECT_W = (N_SECT > 1) ? $clog2(N_SECT) : 1;
  localparam int NCOEF  = 5*N_SECT;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = DATA_W + COEF_W + 3;
  localparam logic [SECT_W-1:0] LAST_SECT = SECT_W'(N_SECT-1);
  localparam logic [ACC_W-1:0]  RND = {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC_W-1);

  typedef enum logic [3:0] {
    S_IDLE, S_A1, S_A2, S_W, S_B0, S_B1, S_B2, S_Y, S_OUT
  } state_t;

  state_t                     r_state;
  logic [SECT_W-1:0]          r_sect;
  logic signed [COEF_W-1:0]   r_coef [NCOEF];
  logic signed [DATA_W-1:0]   r_w1 [N_SECT];
  logic signed [DATA_W-1:0]   r_w2 [N_SECT];
  logic signed [DATA_W-1:0]   r_x;
  logic signed [DATA_W-1:0]   r_w;
  logic signed [DATA_W-1:0]   r_yn;
  logic signed [ACC_W-1:0]    r_acc;
  logic                       r_sat;
  logic                       r_ovf;
  logic                       r_out_valid;

  logic [ADDR_W-1:0]          w_base;
  logic signed [DATA_W-1:0]   w_w1;
  logic signed [DATA_W-1:0]   w_w2;
  logic signed [COEF_W-1:0]   w_mc;
  logic signed [DATA_W-1:0]   w_md;
  logic signed [PROD_W-1:0]   w_prod;
  logic signed [ACC_W-1:0]    w_x_sh;
  logic signed [ACC_W-1:0]    w_acc_base;
  logic signed [ACC_W-1:0]    w_acc_next;
  logic signed [DATA_W:0]     w_sum;
  logic                       w_in_sat;
  logic signed [DATA_W-1:0]   w_x_in;
  logic [DATA_W:0]            w_red;
  logic signed [DATA_W-1:0]   w_red_val;
  logic                       w_red_sat;
  logic                       w_accept;

  // Round-half-up, drop FRAC_W bits, clamp to DATA_W; MSB of result is the clamp flag.
  function automatic logic [DATA_W:0] f_reduce(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] t;
    t = a + $signed(RND);
    t = t >>> FRAC_W;
    if ((&t[ACC_W-1:DATA_W-1]) || !(|t[ACC_W-1:DATA_W-1]))
      f_reduce = {1'b0, t[DATA_W-1:0]};
    else
      f_reduce = {1'b1, t[ACC_W-1], {(DATA_W-1){~t[ACC_W-1]}}};
  endfunction

  assign w_base = ADDR_W'(32'(r_sect) * 32'd5);
  assign w_w1   = r_w1[r_sect];
  assign w_w2   = r_w2[r_sect];
  assign w_x_sh = {{(ACC_W-DATA_W){r_x[DATA_W-1]}}, r_x} << FRAC_W;

  always_comb begin
    w_mc       = '0;
    w_md       = '0;
    w_acc_base = r_acc;
    case (r_state)
      S_A1: begin
        w_mc       = r_coef[w_base + ADDR_W'(3)];
        w_md       = w_w1;
        w_acc_base = w_x_sh;
      end
      S_A2: begin
        w_mc = r_coef[w_base + ADDR_W'(4)];
        w_md = w_w2;
      end
      S_B0: begin
        w_mc       = r_coef[w_base];
        w_md       = r_w;
        w_acc_base = '0;
      end
      S_B1: begin
        w_mc = r_coef[w_base + ADDR_W'(1)];
        w_md = w_w1;
      end
      S_B2: begin
        w_mc = r_coef[w_base + ADDR_W'(2)];
        w_md = w_w2;
      end
      default: ;
    endcase
  end

  assign w_prod     = $signed({{DATA_W{w_mc[COEF_W-1]}}, w_mc}) *
                      $signed({{COEF_W{w_md[DATA_W-1]}}, w_md});
  assign w_acc_next = w_acc_base + {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};

  assign w_sum    = {data_in[DATA_W-1], data_in} + {offset[DATA_W-1], offset};
  assign w_in_sat = w_sum[DATA_W] ^ w_sum[DATA_W-1];
  assign w_x_in   = w_in_sat ? {w_sum[DATA_W], {(DATA_W-1){~w_sum[DATA_W]}}}
                             : w_sum[DATA_W-1:0];

  assign w_red     = f_reduce(r_acc);
  assign w_red_val = w_red[DATA_W-1:0];
  assign w_red_sat = w_red[DATA_W];

  // Register writes and state clears win over a coincident sample.
  assign in_ready  = rst & (r_state == S_IDLE) & ~coef_we & ~clr_state;
  assign w_accept  = in_valid & in_ready;

  assign yn        = r_yn;
  assign out_valid = r_out_valid;
  assign ovf       = r_ovf;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_sect      <= '0;
      r_x         <= '0;
      r_w         <= '0;
      r_yn        <= '0;
      r_acc       <= '0;
      r_sat       <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      for (int i = 0; i < NCOEF; i++) r_coef[i] <= '0;
      for (int s = 0; s < N_SECT; s++) begin
        r_w1[s] <= '0;
        r_w2[s] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (coef_we && (32'(coef_addr) < NCOEF)) r_coef[coef_addr] <= coef_data;
          if (clr_state) begin
            for (int s = 0; s < N_SECT; s++) begin
              r_w1[s] <= '0;
              r_w2[s] <= '0;
            end
          end
          if (w_accept) begin
            r_sat <= w_in_sat;
            if (bypass) begin
              r_yn        <= w_x_in;
              r_ovf       <= w_in_sat;
              r_out_valid <= 1'b1;
              r_state     <= S_OUT;
            end else begin
              r_x     <= w_x_in;
              r_sect  <= '0;
              r_state <= S_A1;
            end
          end
        end
        S_A1: begin
          r_acc   <= w_acc_next;
          r_state <= S_A2;
        end
        S_A2: begin
          r_acc   <= w_acc_next;
          r_state <= S_W;
        end
        S_W: begin
          r_w     <= w_red_val;
          r_sat   <= r_sat | w_red_sat;
          r_state <= S_B0;
        end
        S_B0: begin
          r_acc   <= w_acc_next;
          r_state <= S_B1;
        end
        S_B1: begin
          r_acc   <= w_acc_next;
          r_state <= S_B2;
        end
        S_B2: begin
          r_acc   <= w_acc_next;
          r_state <= S_Y;
        end
        S_Y: begin
          r_w2[r_sect] <= w_w1;
          r_w1[r_sect] <= r_w;
          if (r_sect == LAST_SECT) begin
            r_yn        <= w_red_val;
            r_ovf       <= r_sat | w_red_sat;
            r_out_valid <= 1'b1;
            r_state     <= S_OUT;
          end else begin
            r_x     <= w_red_val;
            r_sat   <= r_sat | w_red_sat;
            r_sect  <= r_sect + SECT_W'(1);
            r_state <= S_A1;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_ovf       <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/iir_biquad_cascade.md
IIR_BIQUAD_CASCADE -- requirements
Module: iir_biquad_cascade

Interface
REQ-001 SHALL have parameter DATA_W, default 32: sample width, signed two's complement.
REQ-002 SHALL have parameter COEF_W, default 32: coefficient width, signed.
REQ-003 SHALL have parameter FRAC_W, default 22: coefficient fraction bits; 1.0 = 2^FRAC_W.
REQ-004 SHALL have parameter N_SECT, default 2: number of cascaded biquad sections, 1..8.
REQ-005 SHALL have port clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports data_in  in  DATA_W  input sample; in_valid  in  1; in_ready  out  1.
REQ-008 SHALL have port offset  in  DATA_W  signed DC offset added to every accepted sample.
REQ-009 SHALL have port bypass  in  1  sampled at acceptance; selects pass-through mode.
REQ-010 SHALL have ports coef_we  in  1; coef_addr  in  clog2(5*N_SECT); coef_data  in  COEF_W  coefficient write port.
REQ-011 SHALL have port clr_state  in  1  zeroes all delay lines.
REQ-012 SHALL have ports yn  out  DATA_W  result; out_valid  out  1; out_ready  in  1; ovf  out  1  saturation flag for yn.

Function
REQ-013 SHALL accept a sample when in_valid & in_ready at a rising edge; in_ready SHALL be 1 only in state IDLE.
REQ-014 SHALL form x = sat(data_in + offset) at acceptance, DATA_W-bit signed saturation.
REQ-015 SHALL compute per section s, with delay lines w1[s], w2[s]: w = x + a1*w1 + a2*w2; y = b0*w + b1*w1 + b2*w2; y of section s is x of section s+1; yn = y of section N_SECT-1.
REQ-016 SHALL store coefficients at address 5*s+k, k = 0..4 -> b0, b1, b2, a1, a2; feedback sign is carried by a1/a2.
REQ-017 SHALL use one shared multiplier; accumulator width DATA_W+COEF_W+3; x is loaded as x<<FRAC_W.
REQ-018 SHALL reduce w and y by adding 2^(FRAC_W-1), arithmetic right shift by FRAC_W, then saturating to DATA_W signed.
REQ-019 SHALL sequence each section through 7 states, one cycle each: A1 (acc = x<<FRAC_W + a1*w1), A2 (acc += a2*w2), W (w = round/sat), B0 (acc = b0*w), B1 (acc += b1*w1), B2 (acc += b2*w2), Y (y = round/sat; w2 <= w1, w1 <= w).
REQ-020 SHALL use states IDLE -> (A1..Y) x N_SECT -> OUT -> IDLE; in bypass it SHALL go IDLE -> OUT, with yn = x and delay lines untouched.
REQ-021 SHALL, for a sample accepted at edge T, assert out_valid 7*N_SECT+1 cycles after T (bypass: 1 cycle).
REQ-022 SHALL hold yn, ovf and out_valid stable in OUT until out_ready = 1, then return to IDLE on that edge.
REQ-023 SHALL set ovf = 1 with out_valid if any W or Y reduction (or the REQ-014 add) saturated for that sample.
REQ-024 SHALL accept coef_we and clr_state only in IDLE; outside IDLE they SHALL be ignored; coef_addr >= 5*N_SECT SHALL be ignored.
REQ-025 SHALL give coef_we and clr_state priority over in_valid when they coincide in IDLE; the sample waits one cycle.

Reset
REQ-026 SHALL, while rst = 0, immediately force: FSM IDLE; all coefficients, delay lines, accumulator and yn = 0; out_valid = 0; ovf = 0; in_ready = 0.
REQ-027 SHALL abort any sample in flight on reset; after release in_ready = 1 on the first cycle.

Verification (DATA_W=16, COEF_W=16, FRAC_W=14, N_SECT=2, offset=0 unless stated)
REQ-028 SHALL cover reset: after release yn=0, out_valid=0, in_ready=1; with coefficients still 0, input 1234 -> yn=0 at cycle T+15.
REQ-029 SHALL cover identity: b0=16384 in both sections, others 0, input 1000, offset=-24 -> yn=976, out_valid first high exactly 15 cycles after acceptance, ovf=0.
REQ-030 SHALL cover rounding and recursion: sect0 b0=8192 then input 3 -> yn=2; sect0 b0=16384, a1=8192, impulse 1000 then zeros -> yn 1000, 500, 250, 125, 63.
REQ-031 SHALL cover saturation: sect0 b0=32767, input 30000 -> yn=32767, ovf=1; input -30000 -> yn=-32768, ovf=1.
REQ-032 SHALL cover handshake and busy writes: out_ready low for 20 cycles holds yn/out_valid, in_ready=0 throughout; coef_we during processing leaves the coefficient unchanged; bypass with input 77 -> yn=77 one cycle after acceptance.
REQ-033 SHALL cover reset mid-operation: rst low during section 1 state B1 -> out_valid=0 at once; after release the next sample is processed with zeroed coefficients.
